mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
Multicycle control sequencer for the MIPS single-cycle datapath (register file, RegDst mux, sign extend, ALUSrc mux, ALU). Accepts one instruction at a time through a valid/ready handshake and latches it. Steps the instruction through FETCH/DECODE/EXEC/MEM/WB, driving the datapath flags and ALUControl in each state. Handles data-memory wait states, branch resolution from Zero, and illegal opcodes.

Parameters:
MEM_TIMEOUT, 16, max cycles in MEM waiting for mem_ready before abort (≥1)
TO_W, 5, width of timeout counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
instr_valid  in  1  upstream has an instruction on instr_in
instr_in  in  32  instruction word
instr_ready  out  1  controller can accept (high only in FETCH)
instruction  out  32  latched IR, drives datapath instruction input
Zero  in  1  ALU zero flag from datapath
mem_ready  in  1  data memory completed current access
ALUScr  out  1  ALU operand B = sign-extended immediate
RegWrite  out  1  register-file write enable
RegDst  out  1  write register = rd (1) / rt (0)
MemRead  out  1  data memory read request
MemWrite  out  1  data memory write request
MemtoReg  out  1  write_data from memory (1) / ALU (0)
ALUControl  out  4  ALU operation select
pc_en  out  1  one-cycle pulse: advance PC
branch_taken  out  1  qualifies pc_en: load branch target
illegal  out  1  sticky: unsupported opcode/funct seen
mem_err  out  1  sticky: MEM timeout occurred

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB. In reset all outputs 0, instruction = 0, state = FETCH. Reset mid-instruction aborts immediately; no pc_en, no RegWrite.
- FETCH: instr_ready=1; on instr_valid&instr_ready latch instr_in to IR, go DECODE. All control outputs 0.
- DECODE: decode IR[31:26], IR[5:0]. Supported: R-type op 0x00 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt; lw 0x23; sw 0x2B; beq 0x04; addi 0x08. Anything else: set illegal, pulse pc_en next cycle (branch_taken=0), return to FETCH (2-cycle skip).
- ALUControl encoding: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100. lw/sw/addi use ADD, beq uses SUB.
- EXEC: ALUControl and ALUScr (1 for lw/sw/addi) driven; both held constant through MEM and WB. beq: branch_taken=Zero, pc_en=1, go FETCH. lw/sw -> MEM. R-type/addi -> WB.
- MEM: MemRead (lw) or MemWrite (sw) held high every cycle until mem_ready sampled 1. lw -> WB. sw: pc_en=1, go FETCH. Timeout counter resets on MEM entry; if MEM_TIMEOUT cycles pass with no mem_ready: drop request, set mem_err, pulse pc_en, go FETCH; no writeback.
- WB (exactly 1 cycle): RegWrite=1; RegDst=1 for R-type else 0; MemtoReg=1 for lw only; pc_en=1; go FETCH.
- Latency from handshake to pc_en, zero memory wait: beq 3, R-type/addi 4, sw 4, lw 5 cycles; each mem wait cycle adds 1.
- Only one of MemRead/MemWrite ever high. RegWrite never high outside WB. pc_en is high at most once per instruction.
- illegal/mem_err are cleared only by reset.

Optional Feature:
MIPS_CTRL_PERFCNT_EN: when defined, adds outputs retired_cnt[31:0] (+1 on every pc_en, including illegal and aborted instructions) and stall_cnt[31:0] (+1 per MEM cycle with mem_ready=0). Both wrap 0xFFFFFFFF->0 and reset to 0. When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- add (0x012A4020), mem unused -> EXEC ALUControl=0010; WB RegWrite=1, RegDst=1, MemtoReg=0; pc_en 4 cycles after handshake.
- lw (0x8D280004), mem_ready asserted after 2 wait cycles -> MemRead high 3 cycles, ALUScr=1; WB MemtoReg=1, RegDst=0; pc_en at cycle 7.
- beq (0x11090003) with Zero=1, then with Zero=0 -> pc_en at cycle 3, branch_taken 1 then 0; RegWrite never high.
- sw, mem_ready never asserted, MEM_TIMEOUT=16 -> MemWrite high 16 cycles then low; mem_err=1; pc_en pulse; FETCH.
- opcode 0x3F -> illegal=1, pc_en after 2 cycles, no RegWrite/MemRead/MemWrite; next valid add executes normally.
- rst=0 during lw MEM -> next edge all outputs 0, state FETCH, instr_ready=1; illegal/mem_err cleared.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for a MIPS
//               datapath. Optional MIPS_CTRL_PERFCNT_EN adds retired and
//               stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr_in,
    output logic        instr_ready,
    output logic [31:0] instruction,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        ALUScr,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic [3:0]  ALUControl,
    output logic        pc_en,
    output logic        branch_taken,
    output logic        illegal,
    output logic        mem_err
`ifdef MIPS_CTRL_PERFCNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {K_R, K_LW, K_SW, K_BEQ, K_ADDI} kind_t;

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d, dec_kind;
    logic [31:0]       ir_q, ir_d;
    logic [3:0]        alu_q, alu_d, dec_alu;
    logic              dec_ok;
    logic              pc_en_q, pc_en_d;
    logic              br_q, br_d;
    logic              illegal_q, illegal_d;
    logic              mem_err_q, mem_err_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              in_alu_phase;

    always_comb begin
        dec_ok   = 1'b1;
        dec_kind = K_R;
        dec_alu  = 4'b0010;
        case (ir_q[31:26])
            6'h00: begin
                case (ir_q[5:0])
                    6'h20:   dec_alu = 4'b0010;
                    6'h22:   dec_alu = 4'b0110;
                    6'h24:   dec_alu = 4'b0000;
                    6'h25:   dec_alu = 4'b0001;
                    6'h27:   dec_alu = 4'b1100;
                    6'h2A:   dec_alu = 4'b0111;
                    default: dec_ok  = 1'b0;
                endcase
            end
            6'h23:   dec_kind = K_LW;
            6'h2B:   dec_kind = K_SW;
            6'h04: begin
                dec_kind = K_BEQ;
                dec_alu  = 4'b0110;
            end
            6'h08:   dec_kind = K_ADDI;
            default: dec_ok   = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        kind_d    = kind_q;
        alu_d     = alu_q;
        pc_en_d   = 1'b0;
        br_d      = 1'b0;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        to_cnt_d  = to_cnt_q;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_ok) begin
                    kind_d  = dec_kind;
                    alu_d   = dec_alu;
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    pc_en_d   = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EXEC: begin
                to_cnt_d = '0;
                case (kind_q)
                    K_BEQ: begin
                        pc_en_d = 1'b1;
                        br_d    = Zero;
                        state_d = S_FETCH;
                    end
                    K_LW, K_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (kind_q == K_LW) begin
                        state_d = S_WB;
                    end else begin
                        pc_en_d = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (to_cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
                    // Abort: the request was outstanding for MEM_TIMEOUT cycles
                    mem_err_d = 1'b1;
                    pc_en_d   = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_WB: begin
                pc_en_d = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            kind_q    <= K_R;
            alu_q     <= '0;
            pc_en_q   <= 1'b0;
            br_q      <= 1'b0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            kind_q    <= kind_d;
            alu_q     <= alu_d;
            pc_en_q   <= pc_en_d;
            br_q      <= br_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // ALU select and operand B stay stable from EXEC through WB
    assign in_alu_phase = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

    assign instr_ready  = (state_q == S_FETCH);
    assign instruction  = ir_q;
    assign ALUControl   = in_alu_phase ? alu_q : 4'b0000;
    assign ALUScr       = in_alu_phase && (kind_q == K_LW || kind_q == K_SW || kind_q == K_ADDI);
    assign MemRead      = (state_q == S_MEM) && (kind_q == K_LW);
    assign MemWrite     = (state_q == S_MEM) && (kind_q == K_SW);
    assign RegWrite     = (state_q == S_WB);
    assign RegDst       = (state_q == S_WB) && (kind_q == K_R);
    assign MemtoReg     = (state_q == S_WB) && (kind_q == K_LW);
    assign pc_en        = pc_en_q;
    assign branch_taken = br_q;
    assign illegal      = illegal_q;
    assign mem_err      = mem_err_q;

`ifdef MIPS_CTRL_PERFCNT_EN
    logic [31:0] retired_q, stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (pc_en_q) begin
                retired_q <= retired_q + 32'd1;
            end
            if ((state_q == S_MEM) && !mem_ready) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

`default_nettype wire
